// File: rtl/pe_tx_nic.sv
// pe_tx_nic: PE-side transmit interface for one cardinal_router mesh node.
// Queues (destination, payload) requests from the local PE. For each queued
// request it builds the mesh header and injects the flit into the router's
// PE input port with the pe_ri/pe_si handshake.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req_valid/ready     PE request handshake
//   req_dst/payload     destination linear index, 32-bit payload
//   pe_ri, pe_polarity  router ready and current VC polarity
//   pe_si, pe_di        one-cycle send strobe and the held flit
//   tx_count            saturating count of injected flits
//   err_self/err_range  one-cycle pulses for dropped requests
module pe_tx_nic #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_W     = 64,
    parameter int NODE_ID    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_dst,
    input  logic [31:0]       req_payload,
    input  logic              pe_ri,
    input  logic              pe_polarity,
    output logic              pe_si,
    output logic [DATA_W-1:0] pe_di,
    output logic [15:0]       tx_count,
    output logic              err_self,
    output logic              err_range
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [8:0] NODES = 9'(ROWS * COLS);
    localparam logic [7:0] SELF  = 8'(NODE_ID);
    localparam logic [7:0] COLS8 = 8'(COLS);
    localparam logic [7:0] SX    = 8'(NODE_ID % COLS);
    localparam logic [7:0] SY    = 8'(NODE_ID / COLS);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t state, state_next;

    logic [7:0]       dst_mem [FIFO_DEPTH];
    logic [31:0]      pay_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_full, fifo_empty;
    logic accept, dst_self, dst_range, push, inject;

    logic [7:0]  head_dst, dx, dy;
    logic [63:0] header;

    // Unary-ish hop field: magnitudes 0..3 map to 0,1,2,4; anything further saturates to 8.
    function automatic logic [3:0] hop(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = (a > b) ? a - b : b - a;
        case (d)
            8'd0:    hop = 4'b0000;
            8'd1:    hop = 4'b0001;
            8'd2:    hop = 4'b0010;
            8'd3:    hop = 4'b0100;
            default: hop = 4'b1000;
        endcase
    endfunction

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // Gated by the reset input so the PE never sees ready during reset.
    assign req_ready  = reset && !fifo_full;

    assign accept    = req_valid && req_ready;
    assign dst_self  = (req_dst == SELF);
    assign dst_range = ({1'b0, req_dst} >= NODES);
    assign push      = accept && !dst_self && !dst_range;

    assign head_dst = dst_mem[rd_ptr];
    assign dx       = head_dst % COLS8;
    assign dy       = head_dst / COLS8;
    assign header   = {1'b0, (dx < SX), (dy >= SY), 5'b0,
                       hop(dx, SX), hop(dy, SY), SX, SY, pay_mem[rd_ptr]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        inject     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && pe_ri) begin
                    inject     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dst_mem[wr_ptr] <= req_dst;
            pay_mem[wr_ptr] <= req_payload;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pe_si     <= 1'b0;
            pe_di     <= '0;
            tx_count  <= '0;
            err_self  <= 1'b0;
            err_range <= 1'b0;
        end else begin
            err_self  <= accept && dst_self;
            err_range <= accept && dst_range;
            pe_si     <= inject;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (inject) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                pe_di  <= {pe_polarity, header[62:0]};
                if (tx_count != 16'hFFFF) tx_count <= tx_count + 16'd1;
            end
            case ({push, inject})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_tx_nic.sv
module tb_pe_tx_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_dst;
    logic [31:0] req_payload;
    logic        pe_ri;
    logic        pe_polarity;
    logic        pe_si;
    logic [63:0] pe_di;
    logic [15:0] tx_count;
    logic        err_self;
    logic        err_range;

    // Auxiliary nodes for header corner cases (node 0 in 4x4 and 6x6 meshes).
    logic        aux_valid;
    logic [7:0]  n0_dst, n6_dst;
    logic [31:0] aux_payload;
    logic        aux_ri, aux_pol;
    logic        n0_ready, n0_si, n0_es, n0_er;
    logic [63:0] n0_di;
    logic [15:0] n0_cnt;
    logic        n6_ready, n6_si, n6_es, n6_er;
    logic [63:0] n6_di;
    logic [15:0] n6_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pe_tx_nic #(.ROWS(4), .COLS(4), .DATA_W(64), .NODE_ID(5), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_dst(req_dst), .req_payload(req_payload), .pe_ri(pe_ri),
        .pe_polarity(pe_polarity), .pe_si(pe_si), .pe_di(pe_di),
        .tx_count(tx_count), .err_self(err_self), .err_range(err_range)
    );

    pe_tx_nic #(.ROWS(4), .COLS(4), .DATA_W(64), .NODE_ID(0), .FIFO_DEPTH(4)) u_n0 (
        .clk(clk), .reset(reset), .req_valid(aux_valid), .req_ready(n0_ready),
        .req_dst(n0_dst), .req_payload(aux_payload), .pe_ri(aux_ri),
        .pe_polarity(aux_pol), .pe_si(n0_si), .pe_di(n0_di),
        .tx_count(n0_cnt), .err_self(n0_es), .err_range(n0_er)
    );

    pe_tx_nic #(.ROWS(6), .COLS(6), .DATA_W(64), .NODE_ID(0), .FIFO_DEPTH(4)) u_n6 (
        .clk(clk), .reset(reset), .req_valid(aux_valid), .req_ready(n6_ready),
        .req_dst(n6_dst), .req_payload(aux_payload), .pe_ri(aux_ri),
        .pe_polarity(aux_pol), .pe_si(n6_si), .pe_di(n6_di),
        .tx_count(n6_cnt), .err_self(n6_es), .err_range(n6_er)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [3:0] mag(input int d);
        int a;
        a = (d < 0) ? -d : d;
        if (a == 0)      return 4'd0;
        else if (a == 1) return 4'd1;
        else if (a == 2) return 4'd2;
        else if (a == 3) return 4'd4;
        else             return 4'd8;
    endfunction

    function automatic logic [62:0] exp_hdr(input int node, input int cols, input int dst,
                                            input logic [31:0] pay);
        int sx, sy, ddx, ddy;
        logic [63:0] h;
        sx  = node % cols;
        sy  = node / cols;
        ddx = dst % cols;
        ddy = dst / cols;
        h = '0;
        h[62]    = (ddx < sx);
        h[61]    = (ddy >= sy);
        h[55:52] = mag(ddx - sx);
        h[51:48] = mag(ddy - sy);
        h[47:40] = sx[7:0];
        h[39:32] = sy[7:0];
        h[31:0]  = pay;
        return h[62:0];
    endfunction

    typedef struct {
        int          dst;
        logic [31:0] pay;
    } req_t;

    req_t        mq[$];
    int          cool;
    logic        e_si, e_es, e_er, e_ready, pre_ready;
    logic [63:0] e_di;
    logic [15:0] e_cnt;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            cool  = 0;
            e_si  = 1'b0;
            e_di  = '0;
            e_cnt = '0;
            e_es  = 1'b0;
            e_er  = 1'b0;
        end else begin
            pre_ready = (mq.size() < 4);
            e_es = req_valid && pre_ready && (req_dst == 8'd5);
            e_er = req_valid && pre_ready && (req_dst >= 8'd16);
            e_si = 1'b0;
            // Successive injections must be at least three edges apart.
            if (cool > 0) begin
                cool--;
            end else if (mq.size() > 0 && pe_ri) begin
                e_di = {pe_polarity, exp_hdr(5, 4, mq[0].dst, mq[0].pay)};
                void'(mq.pop_front());
                e_si = 1'b1;
                if (e_cnt != 16'hFFFF) e_cnt++;
                cool = 2;
            end
            if (req_valid && pre_ready && req_dst != 8'd5 && req_dst < 8'd16)
                mq.push_back('{int'(req_dst), req_payload});
        end
        #1;
        e_ready = reset && (mq.size() < 4);
        chk("pe_si", {63'd0, pe_si}, {63'd0, e_si});
        chk("pe_di", pe_di, e_di);
        chk("tx_count", {48'd0, tx_count}, {48'd0, e_cnt});
        chk("err_self", {63'd0, err_self}, {63'd0, e_es});
        chk("err_range", {63'd0, err_range}, {63'd0, e_er});
        chk("req_ready", {63'd0, req_ready}, {63'd0, e_ready});
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [7:0] d, input logic [31:0] p);
        req_valid   = 1'b1;
        req_dst     = d;
        req_payload = p;
        @(negedge clk);
        req_valid   = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        repeat (limit) begin
            @(posedge clk);
            #1;
            n++;
            if (pe_si) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        int d;

        reset = 1'b0; req_valid = 1'b0; req_dst = '0; req_payload = '0;
        pe_ri = 1'b0; pe_polarity = 1'b0;
        aux_valid = 1'b0; n0_dst = '0; n6_dst = '0; aux_payload = '0;
        aux_ri = 1'b1; aux_pol = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_si", {63'd0, pe_si}, 64'd0);
        chk("rst_di", pe_di, 64'd0);
        chk("rst_cnt", {48'd0, tx_count}, 64'd0);
        chk("rst_ready", {63'd0, req_ready}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single injection, literal header and one-edge latency.
        pe_ri = 1'b1; pe_polarity = 1'b1;
        push(8'd0, 32'd0);
        wait_pulse(8, n, ok);
        chk("t1_seen", {63'd0, ok}, 64'd1);
        chk("t1_latency", 64'(n), 64'd1);
        chk("t1_di", pe_di, 64'hC011010100000000);
        chk("t1_cnt", {48'd0, tx_count}, 64'd1);
        @(negedge clk);

        // Header corners at node 0 in 4x4 and 6x6 meshes.
        aux_valid = 1'b1; n0_dst = 8'd15; n6_dst = 8'd35; aux_payload = 32'hF;
        @(negedge clk);
        aux_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (n0_si) begin
                ok = 1'b1;
                break;
            end
        end
        chk("n0_seen", {63'd0, ok}, 64'd1);
        chk("n0_di", n0_di, 64'h204400000000000F);
        chk("n6_di", n6_di, 64'h208800000000000F);
        repeat (4) @(negedge clk);

        // Backpressure: four accepted, fifth refused, drained in order 3 cycles apart.
        pe_ri = 1'b0; pe_polarity = 1'b0;
        push(8'd1, 32'hA0);
        push(8'd3, 32'hA1);
        push(8'd10, 32'hA2);
        push(8'd15, 32'hA3);
        chk("bp_full_ready", {63'd0, req_ready}, 64'd0);
        push(8'd2, 32'hBAD);
        pe_ri = 1'b1;
        for (int p = 0; p < 4; p++) begin
            wait_pulse(10, n, ok);
            chk("bp_seen", {63'd0, ok}, 64'd1);
            if (p > 0) chk("bp_spacing", 64'(n), 64'd3);
            chk("bp_order", {32'd0, pe_di[31:0]}, 64'(32'hA0 + p));
        end
        repeat (4) @(negedge clk);

        // Drops: self and out-of-range destinations.
        push(8'd5, 32'h55);
        chk("drop_self", {63'd0, err_self}, 64'd1);
        push(8'd16, 32'h66);
        chk("drop_range", {63'd0, err_range}, 64'd1);
        push(8'd200, 32'h77);
        chk("drop_range_far", {63'd0, err_range}, 64'd1);
        pe_ri = 1'b0;
        push(8'd4, 32'hC0);
        push(8'd6, 32'hC1);
        push(8'd7, 32'hC2);
        push(8'd16, 32'hC3);
        chk("drop_keeps_space", {63'd0, req_ready}, 64'd1);
        push(8'd8, 32'hC4);
        chk("drop_then_full", {63'd0, req_ready}, 64'd0);
        pe_ri = 1'b1;
        repeat (16) @(negedge clk);

        // VC stamping with polarity toggling every cycle and a continuous request stream.
        for (int k = 0; k < 24; k++) begin
            pe_polarity = ~pe_polarity;
            d = (k * 7) % 16;
            if (d == 5) d = 12;
            req_valid   = 1'b1;
            req_dst     = 8'(d);
            req_payload = 32'h1000 + 32'(k);
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pe_polarity = ~pe_polarity;
            @(negedge clk);
        end

        // Reset while a flit is on the wire and two requests remain queued.
        pe_ri = 1'b0;
        push(8'd9, 32'hD0);
        push(8'd11, 32'hD1);
        push(8'd13, 32'hD2);
        pe_ri = 1'b1;
        wait_pulse(8, n, ok);
        chk("mid_seen", {63'd0, ok}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_si", {63'd0, pe_si}, 64'd0);
        chk("mid_di", pe_di, 64'd0);
        chk("mid_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_cnt", {48'd0, tx_count}, 64'd0);
        chk("post_si", {63'd0, pe_si}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
